// File: rtl/pump_controller.sv
// Tank fill pump controller: IDLE/FILL/REST/FAULT sequencer with minimum on/off times and dwell timer.
// Optional fill time limit is enabled by defining FILL_TIMEOUT_EN.
module pump_controller #(
  parameter int unsigned MIN_ON_S       = 5,
  parameter int unsigned MIN_OFF_S      = 10,
  parameter int unsigned FILL_TIMEOUT_S = 120
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic       GOET,
  input  logic       LOET,
  input  logic       input_error,
  input  logic       fault_ack,
  output logic       pump_on,
  output logic [2:0] state,
  output logic       fault,
  output logic [7:0] dwell_s
);

  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] MIN_ON    = DW'(MIN_ON_S);
  localparam logic [DW-1:0] MIN_OFF   = DW'(MIN_OFF_S);
  localparam logic [DW-1:0] FILL_TO   = DW'(FILL_TIMEOUT_S);
  localparam logic [DW-1:0] DWELL_MAX = '1;
`ifdef FILL_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    REST  = 3'd2,
    FAULT = 3'd3
  } state_e;

  state_e state_q;
  state_e next_state_c;
  logic   fault_cond_c;

  // Sensor fault: explicit error flag or both thresholds asserted at once.
  assign fault_cond_c = input_error | (GOET & LOET);
  assign state        = state_q;

  // Next-state selection; the fault entry check always comes first.
  always_comb begin
    next_state_c = state_q;
    case (state_q)
      IDLE: begin
        if (fault_cond_c)          next_state_c = FAULT;
        else if (LOET && !GOET)    next_state_c = FILL;
      end
      FILL: begin
        if (fault_cond_c)                               next_state_c = FAULT;
        else if (GOET && (dwell_s >= MIN_ON))           next_state_c = REST;
        else if (TIMEOUT_EN && !GOET && (dwell_s >= FILL_TO)) next_state_c = FAULT;
      end
      REST: begin
        if (fault_cond_c)          next_state_c = FAULT;
        else if (dwell_s >= MIN_OFF) next_state_c = IDLE;
      end
      FAULT: begin
        if (fault_ack && !fault_cond_c) next_state_c = REST;
      end
      default: next_state_c = FAULT;
    endcase
  end

  // State, outputs and dwell timer; a tick coinciding with a state change is dropped.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state_q <= IDLE;
      pump_on <= 1'b0;
      fault   <= 1'b0;
      dwell_s <= '0;
    end else if (next_state_c != state_q) begin
      state_q <= next_state_c;
      pump_on <= (next_state_c == FILL);
      fault   <= (next_state_c == FAULT);
      dwell_s <= '0;
    end else if (tick_1Hz && (dwell_s != DWELL_MAX)) begin
      dwell_s <= dwell_s + 8'd1;
    end
  end

endmodule

// File: tb/tb_pump_controller.sv
// Self-checking bench for pump_controller: directed scenarios then random stimulus vs a rule-level model.
module tb_pump_controller;

  localparam int T_MIN_ON  = 5;
  localparam int T_MIN_OFF = 10;
  localparam int T_FILL_TO = 120;
`ifdef FILL_TIMEOUT_EN
  localparam bit T_TO_EN = 1'b1;
`else
  localparam bit T_TO_EN = 1'b0;
`endif
  localparam int S_IDLE = 0, S_FILL = 1, S_REST = 2, S_FAULT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1Hz = 1'b0;
  logic       GOET = 1'b0;
  logic       LOET = 1'b0;
  logic       input_error = 1'b0;
  logic       fault_ack = 1'b0;
  logic       pump_on;
  logic [2:0] dut_state;
  logic       fault;
  logic [7:0] dwell_s;

  int n_cmp = 0;
  int n_err = 0;
  int ms = S_IDLE;
  int md = 0;

  pump_controller dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .tick_1Hz   (tick_1Hz),
    .GOET       (GOET),
    .LOET       (LOET),
    .input_error(input_error),
    .fault_ack  (fault_ack),
    .pump_on    (pump_on),
    .state      (dut_state),
    .fault      (fault),
    .dwell_s    (dwell_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: which rule fires this second, written as a prioritised list of the requirements.
  task automatic model(input bit r, input bit t, input bit g, input bit l, input bit e, input bit a);
    int  ns;
    bit  bad;
    if (!r) begin
      ms = S_IDLE;
      md = 0;
      return;
    end
    bad = e || (g && l);
    ns  = ms;
    if (ms == S_FAULT) begin
      if (a && !bad) ns = S_REST;
    end else if (bad)                                  ns = S_FAULT;
    else if (ms == S_IDLE && l && !g)                  ns = S_FILL;
    else if (ms == S_FILL && g && md >= T_MIN_ON)      ns = S_REST;
    else if (ms == S_FILL && T_TO_EN && !g && md >= T_FILL_TO) ns = S_FAULT;
    else if (ms == S_REST && md >= T_MIN_OFF)          ns = S_IDLE;
    if (ns != ms) begin
      ms = ns;
      md = 0;
    end else if (t) begin
      md = (md >= 255) ? 255 : md + 1;
    end
  endtask

  task automatic step(input bit r, input bit t, input bit g, input bit l, input bit e, input bit a);
    @(negedge clk);
    reset = r; tick_1Hz = t; GOET = g; LOET = l; input_error = e; fault_ack = a;
    @(posedge clk);
    model(r, t, g, l, e, a);
    #1;
    check("state",   32'(dut_state), 32'(ms));
    check("pump_on", 32'(pump_on),   32'(ms == S_FILL));
    check("fault",   32'(fault),     32'(ms == S_FAULT));
    check("dwell_s", 32'(dwell_s),   32'(md));
  endtask

  initial begin
    bit g, l;
    int lv;
    // Reset state
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1);
    check("reset_state", 32'(dut_state), 32'(S_IDLE));
    check("reset_dwell", 32'(dwell_s), 32'd0);

    // LOET pulse starts the fill; GOET early is held off until MIN_ON_S
    step(1, 0, 0, 1, 0, 0);
    check("loet_fill", 32'(dut_state), 32'(S_FILL));
    check("loet_pump", 32'(pump_on), 32'd1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0);
    check("min_on_hold", 32'(dut_state), 32'(S_FILL));
    check("min_on_dwell", 32'(dwell_s), 32'd5);
    step(1, 0, 1, 0, 0, 0);
    check("min_on_rest", 32'(dut_state), 32'(S_REST));
    check("min_on_pump_off", 32'(pump_on), 32'd0);

    // REST ignores LOET until MIN_OFF_S
    for (int i = 0; i < 10; i++) step(1, 1, 0, 1, 0, 0);
    check("min_off_hold", 32'(dut_state), 32'(S_REST));
    step(1, 0, 0, 1, 0, 0);
    check("min_off_idle", 32'(dut_state), 32'(S_IDLE));
    step(1, 0, 0, 1, 0, 0);
    check("min_off_refill", 32'(dut_state), 32'(S_FILL));

    // Sensor error mid-fill, ack blocked while error persists
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    check("err_fault", 32'(fault), 32'd1);
    check("err_pump", 32'(pump_on), 32'd0);
    step(1, 1, 0, 0, 1, 1);
    check("ack_blocked", 32'(dut_state), 32'(S_FAULT));
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    check("ack_rest", 32'(dut_state), 32'(S_REST));
    check("ack_dwell", 32'(dwell_s), 32'd0);

    // Inconsistent thresholds from IDLE, then reset
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    check("gl_fault", 32'(dut_state), 32'(S_FAULT));
    step(0, 0, 1, 1, 0, 0);
    check("gl_reset", 32'(dut_state), 32'(S_IDLE));
    check("gl_reset_fault", 32'(fault), 32'd0);

    // Tick coincident with IDLE->FILL is dropped
    step(1, 1, 0, 1, 0, 0);
    check("tick_drop", 32'(dwell_s), 32'd0);

    // Long fill: saturation (or timeout when enabled)
    for (int i = 0; i < 260; i++) step(1, 1, 0, 0, 0, 0);
`ifndef FILL_TIMEOUT_EN
    check("sat_state", 32'(dut_state), 32'(S_FILL));
    check("sat_dwell", 32'(dwell_s), 32'd255);
`endif

    // Reset mid-fill drops the pump immediately
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("reset_midfill_pump", 32'(pump_on), 32'd0);

    // Random phase with biased level patterns so every state is reached
    for (int i = 0; i < 4000; i++) begin
      lv = $urandom_range(0, 31);
      if (lv < 10)      begin g = 0; l = 1; end
      else if (lv < 20) begin g = 0; l = 0; end
      else if (lv < 30) begin g = 1; l = 0; end
      else              begin g = 1; l = 1; end
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1), g, l,
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pump_controller.md
PUMP_CONTROLLER -- requirements
Module: pump_controller

Interface
REQ-001 Parameter MIN_ON_S, default 5: minimum pump run time in seconds, range 1..255.
REQ-002 Parameter MIN_OFF_S, default 10: minimum pump rest time in seconds, range 1..255.
REQ-003 Parameter FILL_TIMEOUT_S, default 120: maximum continuous fill time in seconds, range 1..255; used only when FILL_TIMEOUT_EN is defined.
REQ-004 Port clk_100MHz, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 Port tick_1Hz, input, 1 bit: one-cycle enable pulse, once per second.
REQ-007 Port GOET, input, 1 bit: level is greater than or equal to the high threshold.
REQ-008 Port LOET, input, 1 bit: level is less than or equal to the low threshold.
REQ-009 Port input_error, input, 1 bit: the sensor pattern is invalid.
REQ-010 Port fault_ack, input, 1 bit: level-sensitive fault clear request.
REQ-011 Port pump_on, output, 1 bit: pump drive, registered.
REQ-012 Port state, output, 3 bits: current FSM state encoding.
REQ-013 Port fault, output, 1 bit: high while in FAULT.
REQ-014 Port dwell_s, output, 8 bits: whole seconds spent in the current state; saturates at 255.

Function
REQ-015 State encodings SHALL be IDLE=0, FILL=1, REST=2, FAULT=3; codes 4..7 are unused.
REQ-016 pump_on SHALL be 1 only in FILL, registered, and change in the same cycle as the state register.
REQ-017 dwell_s SHALL clear to 0 on every state change and increment by 1 on each tick_1Hz while the state is held, saturating at 255.
REQ-018 A tick_1Hz in the same cycle as a state change SHALL be ignored, so the new state's dwell_s is 0.
REQ-019 IDLE -> FILL when LOET=1 and GOET=0.
REQ-020 FILL -> REST when GOET=1 and dwell_s >= MIN_ON_S.
REQ-021 GOET=1 with dwell_s < MIN_ON_S SHALL keep the FSM in FILL.
REQ-022 REST -> IDLE when dwell_s >= MIN_OFF_S.
REQ-023 While in REST, LOET SHALL be ignored.
REQ-024 Any state except FAULT SHALL go to FAULT when input_error=1, or when GOET=1 and LOET=1 together (inconsistent thresholds).
REQ-025 The FAULT entry condition SHALL take priority over every other transition in the same cycle.
REQ-026 FAULT -> REST when fault_ack=1 and input_error=0 and the GOET/LOET pair is consistent, so the pump always rests MIN_OFF_S after a fault.
REQ-027 fault_ack SHALL be ignored outside FAULT and ignored while the fault condition persists.
REQ-028 An unused state code SHALL force FAULT on the next cycle.
REQ-029 All transitions SHALL have one-cycle latency: a condition sampled at edge N gives the new state and outputs after edge N.

Reset
REQ-030 When reset=0 at a rising edge: state=IDLE, pump_on=0, fault=0, dwell_s=0.
REQ-031 Reset SHALL take effect mid-FILL with pump_on=0 on the next edge, without regard to MIN_ON_S.
REQ-032 The first cycle after reset release SHALL evaluate the IDLE transitions normally.

Configuration
REQ-033 With FILL_TIMEOUT_EN defined: FILL -> FAULT when dwell_s >= FILL_TIMEOUT_S and GOET=0; this has lower priority than REQ-024.
REQ-034 With FILL_TIMEOUT_EN defined: a fill-timeout fault clears by the REQ-026 rule.
REQ-035 Without FILL_TIMEOUT_EN: FILL has no time limit, and the dwell_s width and saturation are unchanged.

Verification
REQ-036 Defaults, reset release, LOET=1 pulse -> FILL and pump_on=1 one cycle later; GOET=1 at dwell_s=2 -> stays in FILL until dwell_s=5, then REST with pump_on=0.
REQ-037 In REST, LOET=1 held -> no FILL before dwell_s=10; IDLE at dwell_s=10, FILL on the next cycle.
REQ-038 input_error=1 during FILL at dwell_s=3 -> FAULT, pump_on=0, fault=1; fault_ack=1 while input_error=1 -> stays in FAULT; drop the error, then ack -> REST with dwell_s=0.
REQ-039 GOET=1 and LOET=1 in IDLE -> FAULT next cycle; reset=0 -> IDLE and all outputs zero.
REQ-040 FILL_TIMEOUT_EN defined, FILL_TIMEOUT_S=4, GOET held at 0 -> FAULT at dwell_s=4; without the macro -> still FILL at dwell_s=255, and dwell_s saturates.
REQ-041 tick_1Hz coincident with the LOET-driven IDLE->FILL transition -> dwell_s=0 in FILL.
